// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 register-transfer datapath.
// Holds PC, MAR, 16x8 RAM, IR, accumulator A, register B, the adder/subtractor
// and the shared 8-bit bus. It is driven by the controller's 12-bit control word
// and returns IR[7:4] as the opcode.
// Optional feature: define SAP_FLAGS_EN to build carry/zero flags; without it
// flag_c and flag_z are constant 0.
module sap_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ctrl,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  opcode,
  output logic [7:0]  bus,
  output logic [7:0]  a_out,
  output logic [3:0]  pc,
  output logic        halted,
  output logic        flag_c,
  output logic        flag_z
);

  // Control word bit positions
  localparam int HLT_B       = 11;
  localparam int PC_INC_B    = 10;
  localparam int PC_EN_B     = 9;
  localparam int MEM_LOAD_B  = 8;
  localparam int MEM_EN_B    = 7;
  localparam int IR_LOAD_B   = 6;
  localparam int IR_EN_B     = 5;
  localparam int A_LOAD_B    = 4;
  localparam int A_EN_B      = 3;
  localparam int B_LOAD_B    = 2;
  localparam int ADDER_SUB_B = 1;
  localparam int ADDER_EN_B  = 0;

  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] ram [16];
  logic [7:0] mem_rd;
  logic [7:0] alu;
  logic       freeze;

  // Adder/subtractor result, modulo 256
  function automatic logic [7:0] alu_result(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic       sub);
    return sub ? (x - y) : (x + y);
  endfunction

  // HLT takes effect in the cycle it is asserted as well as every later one
  assign freeze = halted | ctrl[HLT_B];

  assign mem_rd = ram[mar];
  assign alu    = alu_result(a, b, ctrl[ADDER_SUB_B]);
  assign opcode = ir[7:4];
  assign a_out  = a;

  // Bus source selection with fixed priority; idle bus reads zero
  always_comb begin
    bus = 8'h00;
    if (ctrl[PC_EN_B])         bus = {4'h0, pc};
    else if (ctrl[MEM_EN_B])   bus = mem_rd;
    else if (ctrl[IR_EN_B])    bus = {4'h0, ir[3:0]};
    else if (ctrl[A_EN_B])     bus = a;
    else if (ctrl[ADDER_EN_B]) bus = alu;
  end

  // Program-load port: independent of reset and halt, RAM has no reset
  always_ff @(posedge clk) begin
    if (prog_we) ram[prog_addr] <= prog_data;
  end

  // Architectural registers; frozen once halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 4'h0;
      mar <= 4'h0;
      ir  <= 8'h00;
      a   <= 8'h00;
      b   <= 8'h00;
    end else if (!freeze) begin
      if (ctrl[PC_INC_B])   pc  <= pc + 4'd1;
      if (ctrl[MEM_LOAD_B]) mar <= bus[3:0];
      if (ctrl[IR_LOAD_B])  ir  <= bus;
      if (ctrl[A_LOAD_B])   a   <= bus;
      if (ctrl[B_LOAD_B])   b   <= bus;
    end
  end

  // Halt latch: set by HLT, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               halted <= 1'b0;
    else if (ctrl[HLT_B])  halted <= 1'b1;
  end

`ifdef SAP_FLAGS_EN
  // Carry out on add, no-borrow (a >= b) on subtract
  function automatic logic alu_carry(input logic [7:0] x,
                                     input logic [7:0] y,
                                     input logic       sub);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return sub ? (x >= y) : s[8];
  endfunction

  // Flags update only when an adder result is written back to A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (!freeze && ctrl[ADDER_EN_B] && ctrl[A_LOAD_B]) begin
      flag_c <= alu_carry(a, b, ctrl[ADDER_SUB_B]);
      flag_z <= (alu == 8'h00);
    end
  end
`else
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

endmodule
